// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register (USR) and the blocks
// that drive it: the USR mode encodings and the transmitter state type.
package usr_pkg;

    // Mode encodings understood by the USR.
    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHR  = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

    // Transmitter control states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage : usr_pkg

// File: rtl/usr_serial_tx.sv
// Parallel-to-serial transmitter feeding a downstream USR over its serial
// input. A word accepted through load_valid/load_ready is emitted one bit per
// unpaused cycle. The USR mode lines are driven so that, after the last bit,
// the USR parallel output holds the transmitted word. dir=0 sends LSB first
// for a shift-right consumer; dir=1 sends MSB first for a shift-left consumer.
module usr_serial_tx
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             dir,
    input  logic             pause,
    output logic             serial_out,
    output logic [1:0]       mode_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             dir_q, dir_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             serial_q, serial_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_q, done_d;
    logic             last_bit;
    logic             accept;

    // The last bit only goes out on an unpaused cycle. A new word can be
    // taken on that same edge, which keeps back-to-back frames gap-free.
    assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST) && !pause;
    assign load_ready = (state_q == IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    // Next-state logic: advance or finish the current frame, then let an
    // accepted word override with a fresh frame.
    // NOTE: every signal gets a default before the case, so no path can leave
    // one unassigned and no latch is inferred; blocking '=' is correct here
    // because this is combinational logic, not state.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Nothing to do until a word is accepted; pause is ignored.
            end
            SHIFT: begin
                if (!pause) begin
                    if (cnt_q == LAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Move the next bit to the emitting end.
                        shift_d = dir_q ? (shift_q << 1) : (shift_q >> 1);
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
        endcase

        if (accept) begin
            state_d = SHIFT;
            shift_d = data_in;
            dir_d   = dir;
            cnt_d   = '0;
        end
    end

    // Output values for the next cycle, derived from the next state so that
    // the registered outputs line up with the bit being presented.
    always_comb begin
        serial_d = 1'b0;
        mode_d   = USR_HOLD;
        if (state_d == SHIFT) begin
            serial_d = dir_d ? shift_d[WIDTH-1] : shift_d[0];
            mode_d   = dir_d ? USR_SHL : USR_SHR;
        end
    end

    // Control and output registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            serial_q <= 1'b0;
            mode_q   <= USR_HOLD;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            serial_q <= serial_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    // Datapath registers: word, direction and bit counter.
    // NOTE: these carry no reset because they are always reloaded on accept
    // and are never observed outside the SHIFT state.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        dir_q   <= dir_d;
        cnt_q   <= cnt_d;
    end

    // A paused cycle must hold the USR in the same cycle the counter holds,
    // so pause gates the registered shift mode directly.
    assign mode_out   = pause ? USR_HOLD : mode_q;
    assign serial_out = serial_q;
    assign busy       = (state_q == SHIFT);
    assign frame_done = done_q;

endmodule : usr_serial_tx

// File: tb/tb_usr_serial_tx.sv
// Directed bench for usr_serial_tx driving a 4-bit USR model.
module tb_usr_serial_tx;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             dir;
    logic             pause;
    logic             serial_out;
    logic [1:0]       mode_out;
    logic             busy;
    logic             frame_done;

    logic [WIDTH-1:0] usr_q = '0;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_SHR  = 2'b01;
    localparam logic [1:0] M_SHL  = 2'b10;

    usr_serial_tx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .dir        (dir),
        .pause      (pause),
        .serial_out (serial_out),
        .mode_out   (mode_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Downstream USR model: serial_in enters the MSB on shift-right and the
    // LSB on shift-left.
    always @(posedge clk) begin
        case (mode_out)
            M_SHR:   usr_q <= {serial_out, usr_q[WIDTH-1:1]};
            M_SHL:   usr_q <= {usr_q[WIDTH-2:0], serial_out};
            default: usr_q <= usr_q;
        endcase
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one word from idle and check every bit, the mode, the done pulse
    // and the word that lands in the USR.
    task automatic tx_frame(input logic [3:0] w, input logic d, input string tag);
        logic [1:0] m;
        m = d ? M_SHL : M_SHR;
        load_valid = 1'b1;
        data_in    = w;
        dir        = d;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_ser"}, 8'(serial_out), 8'(d ? w[3-i] : w[i]));
            check({tag, "_mode"}, 8'(mode_out), 8'(m));
            check({tag, "_busy"}, 8'(busy), 8'd1);
            check({tag, "_nodone"}, 8'(frame_done), 8'd0);
            @(negedge clk);
        end
        check({tag, "_done"}, 8'(frame_done), 8'd1);
        check({tag, "_usr"}, 8'(usr_q), 8'(w));
        check({tag, "_hold"}, 8'(mode_out), 8'(M_HOLD));
        check({tag, "_idle"}, 8'(busy), 8'd0);
        @(negedge clk);
        check({tag, "_done1"}, 8'(frame_done), 8'd0);
    endtask

    initial begin
        logic [3:0] wa, wb;

        rst_n      = 1'b0;
        load_valid = 1'b0;
        data_in    = '0;
        dir        = 1'b0;
        pause      = 1'b0;

        // Reset, with a load presented during reset that must be ignored.
        @(negedge clk);
        load_valid = 1'b1;
        data_in    = 4'b1111;
        @(negedge clk);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_mode", 8'(mode_out), 8'(M_HOLD));
        load_valid = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        check("rst_ser", 8'(serial_out), 8'd0);
        check("rst_done", 8'(frame_done), 8'd0);
        check("rst_ready", 8'(load_ready), 8'd1);

        // pause in IDLE has no effect.
        pause = 1'b1;
        #1;
        check("idle_pause_ready", 8'(load_ready), 8'd1);
        check("idle_pause_mode", 8'(mode_out), 8'(M_HOLD));
        @(negedge clk);
        pause = 1'b0;

        // Single frames in each direction.
        tx_frame(4'b1011, 1'b0, "shr1011");
        tx_frame(4'b1100, 1'b1, "shl1100");

        // Back-to-back: 0110 right, then 1001 left accepted in the last-bit cycle.
        wa = 4'b0110;
        wb = 4'b1001;
        load_valid = 1'b1;
        data_in    = wa;
        dir        = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("b2b_a_ser", 8'(serial_out), 8'(wa[i]));
            check("b2b_a_mode", 8'(mode_out), 8'(M_SHR));
            if (i == 3) begin
                check("b2b_ready", 8'(load_ready), 8'd1);
                load_valid = 1'b1;
                data_in    = wb;
                dir        = 1'b1;
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        check("b2b_done_a", 8'(frame_done), 8'd1);
        check("b2b_usr_a", 8'(usr_q), 8'(wa));
        for (int i = 0; i < 4; i++) begin
            if (i > 0) check("b2b_nodone", 8'(frame_done), 8'd0);
            check("b2b_b_ser", 8'(serial_out), 8'(wb[3-i]));
            check("b2b_b_mode", 8'(mode_out), 8'(M_SHL));
            check("b2b_busy", 8'(busy), 8'd1);
            @(negedge clk);
        end
        check("b2b_done_b", 8'(frame_done), 8'd1);
        check("b2b_usr_b", 8'(usr_q), 8'(wb));
        check("b2b_hold", 8'(mode_out), 8'(M_HOLD));
        @(negedge clk);

        // Pause for 3 cycles after two bits, then pause again in the last-bit cycle.
        wa = 4'b1011;
        load_valid = 1'b1;
        data_in    = wa;
        dir        = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("pz_ser", 8'(serial_out), 8'(wa[i]));
            check("pz_mode", 8'(mode_out), 8'(M_SHR));
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            pause = 1'b1;
            #1;
            check("pz_hold_mode", 8'(mode_out), 8'(M_HOLD));
            check("pz_hold_ser", 8'(serial_out), 8'(wa[2]));
            check("pz_hold_busy", 8'(busy), 8'd1);
            @(negedge clk);
        end
        pause = 1'b0;
        #1;
        check("pz_b2_ser", 8'(serial_out), 8'(wa[2]));
        check("pz_b2_mode", 8'(mode_out), 8'(M_SHR));
        @(negedge clk);
        check("pz_b3_ser", 8'(serial_out), 8'(wa[3]));
        pause = 1'b1;
        #1;
        check("pz_last_ready", 8'(load_ready), 8'd0);
        check("pz_last_mode", 8'(mode_out), 8'(M_HOLD));
        @(negedge clk);
        check("pz_last_nodone", 8'(frame_done), 8'd0);
        check("pz_last_busy", 8'(busy), 8'd1);
        pause = 1'b0;
        #1;
        check("pz_last_ready2", 8'(load_ready), 8'd1);
        check("pz_last_mode2", 8'(mode_out), 8'(M_SHR));
        @(negedge clk);
        check("pz_done", 8'(frame_done), 8'd1);
        check("pz_usr", 8'(usr_q), 8'(wa));
        @(negedge clk);

        // Reset after two bits of 1111 aborts the frame.
        load_valid = 1'b1;
        data_in    = 4'b1111;
        dir        = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_mode", 8'(mode_out), 8'(M_HOLD));
        check("abort_busy", 8'(busy), 8'd0);
        check("abort_ser", 8'(serial_out), 8'd0);
        check("abort_done", 8'(frame_done), 8'd0);
        rst_n = 1'b1;
        #1;
        check("abort_ready", 8'(load_ready), 8'd1);
        @(negedge clk);
        check("abort_done2", 8'(frame_done), 8'd0);
        tx_frame(4'b0101, 1'b0, "post_rst0101");

        // load_valid held through mid-frame: only the last-bit-cycle word is taken.
        wa = 4'b1010;
        wb = 4'b0011;
        load_valid = 1'b1;
        data_in    = wa;
        dir        = 1'b0;
        @(negedge clk);
        data_in = wb;
        for (int i = 0; i < 4; i++) begin
            check("ign_ser", 8'(serial_out), 8'(wa[i]));
            check("ign_ready", 8'(load_ready), 8'(i == 3));
            @(negedge clk);
        end
        load_valid = 1'b0;
        check("ign_done_a", 8'(frame_done), 8'd1);
        check("ign_usr_a", 8'(usr_q), 8'(wa));
        for (int i = 0; i < 4; i++) begin
            check("ign_b_ser", 8'(serial_out), 8'(wb[i]));
            check("ign_b_mode", 8'(mode_out), 8'(M_SHR));
            @(negedge clk);
        end
        check("ign_done_b", 8'(frame_done), 8'd1);
        check("ign_usr_b", 8'(usr_q), 8'(wb));
        @(negedge clk);
        check("ign_final_idle", 8'(busy), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_usr_serial_tx
